regfile_write_arbiter: RTL

//  Owns the single write port of the 32x32 integer register file (reg_file).
//  - After reset, a sequencer clears x0..x31 to zero.
//  - It then round-robin arbitrates write-back requests from NUM_REQ units (ALU, load, CSR).
//  - Output is a registered write strobe to the reg_file write port.
//  - Sits between the execute/memory stages and reg_file.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Contents: FSM state enum, register count, requester index assignments.
package regfile_arb_pkg;

  typedef enum logic {ST_CLEAR, ST_ARB} arb_state_t;

  localparam int unsigned NUM_REGS = 32;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_CSR  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester found searching cyclically upward from rr_ptr.
// Ports:
//   req_valid  in   NUM_REQ  pending requests
//   rr_ptr     in   IDX_W    highest-priority requester index this cycle
//   grant      out  NUM_REQ  one-hot grant (zero when nothing is valid)
//   grant_idx  out  IDX_W    index of the granted requester
//   any        out  1        some requester was granted
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at rr_ptr; first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!any && req_valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the reg_file write port. After reset it clears x0..x31 to zero,
// then round-robin arbitrates write-back requests and drives a registered
// write strobe. Writes to x0 are accepted but suppressed.
// Optional macro RF_BYPASS_EN adds a combinational write-to-read forwarding mux.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is combinational)
//   req_rd, req_data      flattened per-requester destination and data
//   write, rd, writedata  registered reg_file write port
//   init_done             high once the clear sequence has finished
//   rs1, rs2, rf_readdata_1/2, readdata_1/2   bypass ports (RF_BYPASS_EN)
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      write,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         writedata,
  output logic                      init_done
`ifdef RF_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  input  logic [DATA_W-1:0]         rf_readdata_1,
  input  logic [DATA_W-1:0]         rf_readdata_2,
  output logic [DATA_W-1:0]         readdata_1,
  output logic [DATA_W-1:0]         readdata_2
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so the counter can reach NUM_REGS, marking a finished clear.
  localparam int unsigned CLR_W = $clog2(NUM_REGS + 1);

  arb_state_t         state, state_n;
  logic [CLR_W-1:0]   clr_idx, clr_idx_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic               write_n, init_done_n;
  logic [ADDR_W-1:0]  rd_n, sel_rd;
  logic [DATA_W-1:0]  writedata_n, sel_data;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Mux out the granted requester's payload.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    clr_idx_n   = clr_idx;
    rr_ptr_n    = rr_ptr;
    write_n     = 1'b0;
    rd_n        = rd;
    writedata_n = writedata;
    init_done_n = init_done;
    req_ready   = '0;
    case (state)
      ST_CLEAR: begin
        if (clr_idx == CLR_W'(NUM_REGS)) begin
          state_n     = ST_ARB;
          init_done_n = 1'b1;
        end else begin
          write_n     = 1'b1;
          rd_n        = ADDR_W'(clr_idx);
          writedata_n = '0;
          clr_idx_n   = clr_idx + CLR_W'(1);
        end
      end
      ST_ARB: begin
        req_ready = grant;
        if (grant_any) begin
          rr_ptr_n = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          // x0 is hard-wired zero: accept the transfer but drop the write.
          if (sel_rd != '0) begin
            write_n     = 1'b1;
            rd_n        = sel_rd;
            writedata_n = sel_data;
          end
        end
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_idx   <= '0;
      rr_ptr    <= '0;
      write     <= 1'b0;
      rd        <= '0;
      writedata <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      clr_idx   <= clr_idx_n;
      rr_ptr    <= rr_ptr_n;
      write     <= write_n;
      rd        <= rd_n;
      writedata <= writedata_n;
      init_done <= init_done_n;
    end
  end

`ifdef RF_BYPASS_EN
  // Forward the in-flight write so a same-cycle read sees the new value.
  assign readdata_1 = (write && rd != '0 && rd == rs1) ? writedata : rf_readdata_1;
  assign readdata_2 = (write && rd != '0 && rd == rs2) ? writedata : rf_readdata_2;
`endif

endmodule
